rapcore_spi_initiator: RTL and testbench

//  Wishbone-controlled SPI initiator (controller) for the rapcore SPI responder.

---
 rtl/rapcore_spi_initiator_if.sv | 25 ++
 rtl/rapcore_spi_initiator.sv | 250 +++++++++++++++++++++++++
 tb/tb_rapcore_spi_initiator.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rapcore_spi_initiator_if.sv
// Wishbone slave bus bundle for the rapcore SPI initiator register block.
// Latency: none (wires only).
// Backpressure: none; the slave acks every access one cycle after cyc&stb.
interface rapcore_spi_initiator_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  // SoC side drives the request, sees ack/read data
  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );

  // Register block side
  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/rapcore_spi_initiator.sv
// Wishbone-controlled SPI mode-0 initiator (MSB first, CS active-low) for rapcore.
// Latency: TXDATA write -> cs fall 1 clk; transfer (2*DATA_BITS+2)*DIV clks + DIV clks deselect.
// Backpressure: WB always acked next cycle; TXDATA writes while busy are dropped and flag OVERRUN.
// Optional: define SPI_LOOPBACK_EN to add CTRL[1] LOOP (copi fed back into the sampler).
module rapcore_spi_initiator #(
  parameter int          DATA_BITS = 32,
  parameter logic [15:0] DIV_RESET = 16'd4
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  rapcore_spi_initiator_if.slave   wb,
  output logic                     spi_sck_o,
  output logic                     spi_cs_o,
  output logic                     spi_copi_o,
  input  logic                     spi_cipo_i,
  output logic                     busy_o
);

  localparam int              BW       = 6;
  localparam logic [BW-1:0]   LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW,
    ST_TAIL,
    ST_HOLDOFF
  } state_t;

  state_t                 state_q, state_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   tx_q, tx_d;
  logic [DATA_BITS-1:0]   rx_q, rx_d;
  logic                   sck_d, cs_d, copi_d;
  logic                   rx_done;

  logic [15:0]            div_q;
  logic                   hold_q;
  logic                   rx_valid_q;
  logic                   overrun_q;
  logic [DATA_BITS-1:0]   rx_data_q;
`ifdef SPI_LOOPBACK_EN
  logic                   loop_q;
`endif

  logic                   access, wr_en, rd_en;
  logic [1:0]             reg_sel;
  logic                   busy;
  logic                   start, tx_overrun;
  logic [31:0]            rd_data;
  logic [15:0]            div_eff, reload;
  logic                   phase_end;
  logic [DATA_BITS-1:0]   tx_word, tx_shift, rx_shift;
  logic                   samp_src;
  logic [1:0]             cipo_sync;
  logic                   unused_bits;

  // Bus decode: one access per two clocks since a pending ack blocks the next one
  assign access  = wb.wbs_cyc_i & wb.wbs_stb_i & ~wb.wbs_ack_o;
  assign wr_en   = access & wb.wbs_we_i & (wb.wbs_sel_i != 4'b0000);
  assign rd_en   = access & ~wb.wbs_we_i;
  assign reg_sel = wb.wbs_adr_i[3:2];
  assign unused_bits = ^{wb.wbs_adr_i[31:4], wb.wbs_adr_i[1:0], wb.wbs_dat_i};

  assign busy       = (state_q != ST_IDLE);
  assign busy_o     = busy;
  assign start      = wr_en && (reg_sel == 2'd2) && !busy;
  assign tx_overrun = wr_en && (reg_sel == 2'd2) && busy;
  assign tx_word    = wb.wbs_dat_i[DATA_BITS-1:0];

  // A divider of zero would stall the half-period counter, so it runs as one
  assign div_eff   = (div_q == 16'd0) ? 16'd1 : div_q;
  assign reload    = div_eff - 16'd1;
  assign phase_end = (cnt_q == 16'd0);

  assign tx_shift = tx_q << 1;
  assign rx_shift = (rx_q << 1) | DATA_BITS'(cipo_sync[1]);

`ifdef SPI_LOOPBACK_EN
  assign samp_src = loop_q ? spi_copi_o : spi_cipo_i;
`else
  assign samp_src = spi_cipo_i;
`endif

  // Two-flop synchroniser on the sampled data line
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) cipo_sync <= 2'b00;
    else          cipo_sync <= {cipo_sync[0], samp_src};
  end

  // Read mux; unmapped or write-only locations read as zero
  always_comb begin
    rd_data = '0;
    case (reg_sel)
      2'd0: begin
        rd_data[23:8] = div_q;
        rd_data[0]    = hold_q;
`ifdef SPI_LOOPBACK_EN
        rd_data[1]    = loop_q;
`endif
      end
      2'd1:    rd_data[2:0] = {overrun_q, rx_valid_q, busy};
      2'd3:    rd_data[DATA_BITS-1:0] = rx_data_q;
      default: rd_data = '0;
    endcase
  end

  // Register file, WB ack/read data and status flags
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb.wbs_ack_o <= 1'b0;
      wb.wbs_dat_o <= '0;
      div_q        <= DIV_RESET;
      hold_q       <= 1'b0;
      rx_valid_q   <= 1'b0;
      overrun_q    <= 1'b0;
      rx_data_q    <= '0;
`ifdef SPI_LOOPBACK_EN
      loop_q       <= 1'b0;
`endif
    end else begin
      wb.wbs_ack_o <= access;
      wb.wbs_dat_o <= rd_en ? rd_data : '0;
      // Any non-zero byte select commits the whole word
      if (wr_en && (reg_sel == 2'd0)) begin
        div_q  <= wb.wbs_dat_i[23:8];
        hold_q <= wb.wbs_dat_i[0];
`ifdef SPI_LOOPBACK_EN
        loop_q <= wb.wbs_dat_i[1];
`endif
      end
      if (tx_overrun)
        overrun_q <= 1'b1;
      else if (wr_en && (reg_sel == 2'd1) && wb.wbs_dat_i[2])
        overrun_q <= 1'b0;
      // Completion wins over a simultaneous RXDATA read so new data is never lost
      if (rx_done)
        rx_valid_q <= 1'b1;
      else if (rd_en && (reg_sel == 2'd3))
        rx_valid_q <= 1'b0;
      if (rx_done)
        rx_data_q <= rx_q;
    end
  end

  // Transfer FSM state and datapath registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      spi_sck_o  <= 1'b0;
      spi_cs_o   <= 1'b1;
      spi_copi_o <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      spi_sck_o  <= sck_d;
      spi_cs_o   <= cs_d;
      spi_copi_o <= copi_d;
    end
  end

  // Next-state logic; each phase lasts DIV clocks, counter reloads at phase change.
  // Data is sampled at the end of the high phase so the synchroniser has settled.
  always_comb begin
    state_d = state_q;
    cnt_d   = phase_end ? cnt_q : cnt_q - 16'd1;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    sck_d   = spi_sck_o;
    cs_d    = spi_cs_o;
    copi_d  = spi_copi_o;
    rx_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        sck_d = 1'b0;
        if (start) begin
          // With HOLD latched cs is already low; the setup half-period still runs
          tx_d    = tx_word;
          copi_d  = tx_word[DATA_BITS-1];
          rx_d    = '0;
          bit_d   = '0;
          cs_d    = 1'b0;
          cnt_d   = reload;
          state_d = ST_SETUP;
        end else if (!spi_cs_o && !hold_q) begin
          cs_d    = 1'b1;
          cnt_d   = reload;
          state_d = ST_HOLDOFF;
        end
      end
      ST_SETUP: begin
        if (phase_end) begin
          sck_d   = 1'b1;
          cnt_d   = reload;
          state_d = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (phase_end) begin
          rx_d    = rx_shift;
          tx_d    = tx_shift;
          copi_d  = tx_shift[DATA_BITS-1];
          sck_d   = 1'b0;
          cnt_d   = reload;
          state_d = ST_LOW;
        end
      end
      ST_LOW: begin
        if (phase_end) begin
          cnt_d = reload;
          if (bit_q == LAST_BIT) begin
            state_d = ST_TAIL;
          end else begin
            bit_d   = bit_q + 1'b1;
            sck_d   = 1'b1;
            state_d = ST_HIGH;
          end
        end
      end
      ST_TAIL: begin
        if (phase_end) begin
          rx_done = 1'b1;
          copi_d  = 1'b0;
          if (hold_q) begin
            state_d = ST_IDLE;
          end else begin
            cs_d    = 1'b1;
            cnt_d   = reload;
            state_d = ST_HOLDOFF;
          end
        end
      end
      ST_HOLDOFF: begin
        if (phase_end) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rapcore_spi_initiator.sv
// Directed bench for rapcore_spi_initiator with a mode-0 responder model and SPI monitor.
// Latency: n/a (testbench).
// Backpressure: n/a; bus accesses wait a bounded number of cycles for ack.
module tb_rapcore_spi_initiator;
  logic clk = 1'b0;
  logic rst;
  logic spi_sck, spi_cs, spi_copi, spi_cipo, busy;

  rapcore_spi_initiator_if bus();

  rapcore_spi_initiator dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wb         (bus),
    .spi_sck_o  (spi_sck),
    .spi_cs_o   (spi_cs),
    .spi_copi_o (spi_copi),
    .spi_cipo_i (spi_cipo),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Responder word, written only by the stimulus process
  logic [31:0] resp = 32'h0;

  // Monitor/responder state, written only by the monitor process
  int          cyc = 0, rises = 0, cs_rises = 0, period = 0, last_rise = 0;
  int          cs_fall_cyc = 0, cs_rise_cyc = 0, ridx = -1;
  logic [31:0] copi_cap = 32'h0;
  logic        cs_q = 1'b1, sck_q = 1'b0, busy_q = 1'b0;
  logic        cipo_r = 1'b0;
  assign spi_cipo = cipo_r;

  // Mode-0 responder (restarts at each transfer start, shifts on sck fall) and edge monitor
  always @(negedge clk) begin
    cyc++;
    if (!busy_q && busy) begin
      cipo_r = resp[31];
      ridx   = 30;
    end else if (!spi_cs && sck_q && !spi_sck) begin
      if (ridx >= 0) begin
        cipo_r = resp[ridx];
        ridx--;
      end else begin
        cipo_r = 1'b0;
      end
    end
    if (!sck_q && spi_sck) begin
      rises++;
      copi_cap  = {copi_cap[30:0], spi_copi};
      period    = cyc - last_rise;
      last_rise = cyc;
    end
    if (cs_q && !spi_cs) cs_fall_cyc = cyc;
    if (!cs_q && spi_cs) begin
      cs_rises++;
      cs_rise_cyc = cyc;
    end
    cs_q   = spi_cs;
    sck_q  = spi_sck;
    busy_q = busy;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic wb_xfer(input logic we, input logic [1:0] idx, input logic [31:0] d,
                         input logic [3:0] sel, output logic [31:0] q);
    int n;
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_sel_i = sel;
    bus.wbs_adr_i = {28'h0, idx, 2'b00};
    bus.wbs_dat_i = d;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.wbs_ack_o && n < 8);
    q = bus.wbs_dat_o;
    if (!bus.wbs_ack_o) check("wb_ack_timeout", 32'd0, 32'd1);
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
  endtask

  task automatic wb_wr(input logic [1:0] idx, input logic [31:0] d);
    logic [31:0] q;
    wb_xfer(1'b1, idx, d, 4'hF, q);
  endtask

  task automatic wb_rd(input logic [1:0] idx, output logic [31:0] q);
    wb_xfer(1'b0, idx, 32'h0, 4'hF, q);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({"idle_", tag}, {31'b0, busy}, 32'd0);
  endtask

  logic [31:0] q;
  int          base_rises, base_cs_rises, n;

  initial begin
    rst = 1'b1;
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = 32'h0; bus.wbs_dat_i = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_sck",  {31'b0, spi_sck},  32'd0);
    check("rst_cs",   {31'b0, spi_cs},   32'd1);
    check("rst_copi", {31'b0, spi_copi}, 32'd0);
    check("rst_busy", {31'b0, busy},     32'd0);
    check("rst_ack",  {31'b0, bus.wbs_ack_o}, 32'd0);
    check("rst_dat",  bus.wbs_dat_o, 32'h0);
    wb_rd(2'd0, q); check("rst_ctrl", q, 32'h0000_0400);
    wb_rd(2'd1, q); check("rst_stat", q, 32'h0);
    wb_rd(2'd3, q); check("rst_rx",   q, 32'h0);

    // Ack is one pulse per access even with stb held
    @(negedge clk); @(negedge clk);
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
    bus.wbs_adr_i = 32'h4;
    @(posedge clk); #1; check("ack_first",  {31'b0, bus.wbs_ack_o}, 32'd1);
    @(posedge clk); #1; check("ack_gap",    {31'b0, bus.wbs_ack_o}, 32'd0);
    check("dat_no_ack", bus.wbs_dat_o, 32'h0);
    @(posedge clk); #1; check("ack_second", {31'b0, bus.wbs_ack_o}, 32'd1);
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;

    // Test 1: DIV=2 full transfer
    wb_wr(2'd0, 32'h0000_0200);
    resp = 32'h1234_5678;
    base_rises = rises;
    wb_wr(2'd2, 32'hA5C3_0F01);
    check("t1_cs_fall_1clk", {31'b0, spi_cs}, 32'd0);
    check("t1_busy_start",   {31'b0, busy},   32'd1);
    wait_idle("t1");
    check("t1_rises",    rises - base_rises, 32);
    check("t1_period",   period, 4);
    check("t1_copi",     copi_cap, 32'hA5C3_0F01);
    check("t1_cs_len",   cs_rise_cyc - cs_fall_cyc, 132);
    check("t1_cs_high",  {31'b0, spi_cs}, 32'd1);
    wb_rd(2'd1, q); check("t1_stat_rxv", q, 32'h2);
    wb_rd(2'd3, q); check("t1_rxdata",   q, 32'h1234_5678);
    wb_rd(2'd1, q); check("t1_stat_clr", q, 32'h0);

    // Test 2: TXDATA write while busy
    resp = 32'h5555_AAAA;
    base_rises = rises;
    wb_wr(2'd2, 32'h0F0F_0F0F);
    repeat (10) @(negedge clk);
    wb_wr(2'd2, 32'hFFFF_FFFF);
    wb_rd(2'd1, q); check("t2_stat_ovr_busy", q, 32'h5);
    wait_idle("t2");
    check("t2_rises", rises - base_rises, 32);
    check("t2_copi",  copi_cap, 32'h0F0F_0F0F);
    wb_rd(2'd1, q); check("t2_stat_done", q, 32'h6);
    wb_rd(2'd3, q); check("t2_rxdata",    q, 32'h5555_AAAA);
    wb_wr(2'd1, 32'h4);
    wb_rd(2'd1, q); check("t2_ovr_clear", q, 32'h0);
    wb_xfer(1'b1, 2'd0, 32'h0, 4'h0, q);
    wb_rd(2'd0, q); check("t2_sel0_noop", q, 32'h0000_0200);

    // Test 3: HOLD keeps cs low across two words
    wb_wr(2'd0, 32'h0000_0201);
    resp = 32'h1357_9BDF;
    base_rises = rises;
    base_cs_rises = cs_rises;
    wb_wr(2'd2, 32'h1111_1111);
    wait_idle("t3a");
    check("t3_cs_held", {31'b0, spi_cs}, 32'd0);
    wb_wr(2'd2, 32'h2222_2222);
    wait_idle("t3b");
    check("t3_no_cs_rise", cs_rises - base_cs_rises, 0);
    check("t3_rises",      rises - base_rises, 64);
    check("t3_copi",       copi_cap, 32'h2222_2222);
    wb_wr(2'd0, 32'h0000_0200);
    check("t3_cs_before", {31'b0, spi_cs}, 32'd0);
    @(posedge clk); #1;
    check("t3_cs_rise", {31'b0, spi_cs}, 32'd1);
    check("t3_busy1",   {31'b0, busy},   32'd1);
    @(posedge clk); #1; check("t3_busy2", {31'b0, busy}, 32'd1);
    @(posedge clk); #1; check("t3_busy3", {31'b0, busy}, 32'd0);
    wb_rd(2'd3, q); check("t3_rxdata", q, 32'h1357_9BDF);

    // Test 4: reset in the middle of a transfer
    resp = 32'hFFFF_FFFF;
    base_rises = rises;
    wb_wr(2'd2, 32'h3C3C_3C3C);
    n = 0;
    while ((rises - base_rises) < 10 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("t4_reach_bit10", rises - base_rises, 10);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t4_sck",  {31'b0, spi_sck},  32'd0);
    check("t4_cs",   {31'b0, spi_cs},   32'd1);
    check("t4_busy", {31'b0, busy},     32'd0);
    check("t4_copi", {31'b0, spi_copi}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wb_rd(2'd3, q); check("t4_rx",   q, 32'h0);
    wb_rd(2'd1, q); check("t4_stat", q, 32'h0);
    wb_rd(2'd0, q); check("t4_ctrl", q, 32'h0000_0400);

    // Test 5: DIV=0 runs as DIV=1
    wb_wr(2'd0, 32'h0);
    wb_rd(2'd0, q); check("t5_ctrl", q, 32'h0);
    resp = 32'h0;
    base_rises = rises;
    wb_wr(2'd2, 32'h8000_0001);
    wait_idle("t5");
    check("t5_rises",  rises - base_rises, 32);
    check("t5_period", period, 2);
    check("t5_copi",   copi_cap, 32'h8000_0001);
    check("t5_cs_len", cs_rise_cyc - cs_fall_cyc, 66);
    wb_rd(2'd1, q); check("t5_stat_rxv", q, 32'h2);
    wb_rd(2'd3, q);
    wb_rd(2'd1, q); check("t5_stat_clr", q, 32'h0);

`ifdef SPI_LOOPBACK_EN
    // Test 6: loopback returns the transmitted word
    wb_wr(2'd0, 32'h0000_0202);
    wb_rd(2'd0, q); check("t6_ctrl", q, 32'h0000_0202);
    resp = 32'h0;
    wb_wr(2'd2, 32'hDEAD_BEEF);
    wait_idle("t6");
    wb_rd(2'd3, q); check("t6_loop_rx", q, 32'hDEAD_BEEF);
`else
    // Without loopback CTRL[1] reads back as zero
    wb_wr(2'd0, 32'h0000_0202);
    wb_rd(2'd0, q); check("t6_loop_ro", q, 32'h0000_0200);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
